// File: rtl/prf_banked_arb_if.sv
// Read-request / read-response / writeback signal bundle for prf_banked_arb.
// The master side is the issue stage and writeback buses; the slave side is the register file.
interface prf_banked_arb_if #(
  parameter int PR_COUNT   = 64,
  parameter int DATA_WIDTH = 32,
  parameter int RR_COUNT   = 4,
  parameter int WR_COUNT   = 2
);
  localparam int LOG_PR_COUNT = $clog2(PR_COUNT);

  logic [RR_COUNT-1:0]                   read_req_valid_by_rr;
  logic [RR_COUNT-1:0][LOG_PR_COUNT-1:0] read_req_PR_by_rr;
  logic [RR_COUNT-1:0]                   read_req_ready_by_rr;
  logic [RR_COUNT-1:0]                   read_resp_valid_by_rr;
  logic [RR_COUNT-1:0][DATA_WIDTH-1:0]   read_resp_data_by_rr;
  logic [WR_COUNT-1:0]                   WB_valid_by_wr;
  logic [WR_COUNT-1:0][DATA_WIDTH-1:0]   WB_data_by_wr;
  logic [WR_COUNT-1:0][LOG_PR_COUNT-1:0] WB_PR_by_wr;

  modport master (
    output read_req_valid_by_rr, read_req_PR_by_rr,
    output WB_valid_by_wr, WB_data_by_wr, WB_PR_by_wr,
    input  read_req_ready_by_rr, read_resp_valid_by_rr, read_resp_data_by_rr
  );

  modport slave (
    input  read_req_valid_by_rr, read_req_PR_by_rr,
    input  WB_valid_by_wr, WB_data_by_wr, WB_PR_by_wr,
    output read_req_ready_by_rr, read_resp_valid_by_rr, read_resp_data_by_rr
  );
endinterface

// File: rtl/prf_banked_arb.sv
// Banked physical register file: round-robin read-port arbitration per bank,
// registered read responses and same-cycle writeback forwarding. PR 0 is hard zero.
module prf_banked_arb #(
  parameter int PR_COUNT       = 64,
  parameter int DATA_WIDTH     = 32,
  parameter int RR_COUNT       = 4,
  parameter int WR_COUNT       = 2,
  parameter int BANK_COUNT     = 2,
  parameter int PORTS_PER_BANK = 1
) (
  input  logic             CLK,
  input  logic             nRST,
  prf_banked_arb_if.slave  bus
);
  localparam int PTR_W = (RR_COUNT > 1) ? $clog2(RR_COUNT) : 1;
  typedef logic [PTR_W-1:0] ptr_t;

  logic [DATA_WIDTH-1:0]               regs [PR_COUNT];
  ptr_t                                rr_ptr     [BANK_COUNT];
  ptr_t                                rr_ptr_nxt [BANK_COUNT];
  logic [RR_COUNT-1:0]                 pr_zero;
  logic [RR_COUNT-1:0]                 bank_grant;
  logic [RR_COUNT-1:0]                 xfer;
  logic [RR_COUNT-1:0][DATA_WIDTH-1:0] rd_data;

  always_comb begin
    for (int r = 0; r < RR_COUNT; r++) begin
      pr_zero[r] = (bus.read_req_PR_by_rr[r] == '0);
    end
  end

  // Per bank: walk requesters from the pointer, wrapping, and take the first
  // PORTS_PER_BANK eligible ones. PR 0 reads never compete for a bank port.
  always_comb begin
    ptr_t idx;
    int   pos;
    int   cnt;
    idx        = '0;
    pos        = 0;
    cnt        = 0;
    bank_grant = '0;
    for (int b = 0; b < BANK_COUNT; b++) begin
      rr_ptr_nxt[b] = rr_ptr[b];
      cnt           = 0;
      for (int k = 0; k < RR_COUNT; k++) begin
        pos = int'(rr_ptr[b]) + k;
        if (pos >= RR_COUNT) pos = pos - RR_COUNT;
        idx = ptr_t'(pos);
        if (bus.read_req_valid_by_rr[idx] && !pr_zero[idx] &&
            ((int'(bus.read_req_PR_by_rr[idx]) & (BANK_COUNT - 1)) == b) &&
            (cnt < PORTS_PER_BANK)) begin
          bank_grant[idx] = 1'b1;
          cnt             = cnt + 1;
          rr_ptr_nxt[b]   = (pos == RR_COUNT - 1) ? '0 : ptr_t'(pos + 1);
        end
      end
    end
  end

  assign xfer                     = bank_grant | (bus.read_req_valid_by_rr & pr_zero);
  assign bus.read_req_ready_by_rr = xfer;

  // Later writeback index overrides earlier ones so the highest wr wins, matching the array write order.
  always_comb begin
    for (int r = 0; r < RR_COUNT; r++) begin
      rd_data[r] = regs[bus.read_req_PR_by_rr[r]];
      for (int w = 0; w < WR_COUNT; w++) begin
        if (bus.WB_valid_by_wr[w] && (bus.WB_PR_by_wr[w] != '0) &&
            (bus.WB_PR_by_wr[w] == bus.read_req_PR_by_rr[r])) begin
          rd_data[r] = bus.WB_data_by_wr[w];
        end
      end
      if (pr_zero[r]) rd_data[r] = '0;
    end
  end

  // NOTE: the array is a flop array, not a RAM macro, so it can and must clear on reset.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < PR_COUNT; i++) regs[i] <= '0;
    end else begin
      for (int w = 0; w < WR_COUNT; w++) begin
        if (bus.WB_valid_by_wr[w] && (bus.WB_PR_by_wr[w] != '0)) begin
          regs[bus.WB_PR_by_wr[w]] <= bus.WB_data_by_wr[w];
        end
      end
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int b = 0; b < BANK_COUNT; b++) rr_ptr[b] <= '0;
    end else begin
      for (int b = 0; b < BANK_COUNT; b++) rr_ptr[b] <= rr_ptr_nxt[b];
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      bus.read_resp_valid_by_rr <= '0;
      bus.read_resp_data_by_rr  <= '0;
    end else begin
      bus.read_resp_valid_by_rr <= xfer;
      for (int r = 0; r < RR_COUNT; r++) begin
        if (xfer[r]) bus.read_resp_data_by_rr[r] <= rd_data[r];
      end
    end
  end
endmodule

// File: tb/tb_prf_banked_arb.sv
// Directed bench for prf_banked_arb: expected responses are queued when a grant is
// expected and compared when the registered response appears one cycle later.
module tb_prf_banked_arb;
  localparam logic [31:0] V2 = 32'hA2A2_0002;
  localparam logic [31:0] V4 = 32'hA4A4_0004;
  localparam logic [31:0] V6 = 32'hA6A6_0006;
  localparam logic [31:0] V8 = 32'hA8A8_0008;

  logic CLK = 1'b0;
  logic nRST;
  always #5 CLK = ~CLK;

  prf_banked_arb_if bus ();
  prf_banked_arb dut (.CLK(CLK), .nRST(nRST), .bus(bus));

  typedef struct packed {
    logic [1:0]  rr;
    logic [31:0] data;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive_rd(input logic [3:0] v, input logic [5:0] p0, input logic [5:0] p1,
                          input logic [5:0] p2, input logic [5:0] p3);
    bus.read_req_valid_by_rr = v;
    bus.read_req_PR_by_rr[0] = p0;
    bus.read_req_PR_by_rr[1] = p1;
    bus.read_req_PR_by_rr[2] = p2;
    bus.read_req_PR_by_rr[3] = p3;
  endtask

  task automatic drive_wb(input logic v0, input logic [5:0] p0, input logic [31:0] d0,
                          input logic v1, input logic [5:0] p1, input logic [31:0] d1);
    bus.WB_valid_by_wr = {v1, v0};
    bus.WB_PR_by_wr[0] = p0;
    bus.WB_PR_by_wr[1] = p1;
    bus.WB_data_by_wr[0] = d0;
    bus.WB_data_by_wr[1] = d1;
  endtask

  // One clock: ready checked on the negedge, response checked 1 ns after the posedge.
  task automatic step(input string tag, input logic [3:0] exp_rdy,
                      input logic [31:0] e0, input logic [31:0] e1,
                      input logic [31:0] e2, input logic [31:0] e3);
    logic [31:0] e [4];
    logic [3:0]  exp_vld;
    exp_t        got;
    e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
    exp_vld = '0;
    @(negedge CLK);
    for (int r = 0; r < 4; r++) begin
      if (bus.read_req_valid_by_rr[r]) begin
        check($sformatf("%s_ready%0d", tag, r), 32'(bus.read_req_ready_by_rr[r]), 32'(exp_rdy[r]));
        if (exp_rdy[r]) begin
          sb.push_back('{rr: 2'(r), data: e[r]});
          exp_vld[r] = 1'b1;
        end
      end
    end
    @(posedge CLK);
    #1;
    check({tag, "_resp_valid"}, 32'(bus.read_resp_valid_by_rr), 32'(exp_vld));
    for (int r = 0; r < 4; r++) begin
      if (exp_vld[r] && bus.read_resp_valid_by_rr[r]) begin
        got = sb.pop_front();
        check($sformatf("%s_data%0d", tag, got.rr), bus.read_resp_data_by_rr[r], got.data);
      end
    end
  endtask

  initial begin
    nRST = 1'b0;
    drive_rd(4'b0000, 0, 0, 0, 0);
    drive_wb(0, 0, 0, 0, 0, 0);
    repeat (3) @(posedge CLK);
    #1;
    check("rst_resp_valid", 32'(bus.read_resp_valid_by_rr), 32'd0);
    for (int r = 0; r < 4; r++)
      check($sformatf("rst_resp_data%0d", r), bus.read_resp_data_by_rr[r], 32'd0);
    @(negedge CLK);
    nRST = 1'b1;
    @(posedge CLK);
    #1;

    drive_rd(4'b0001, 5, 0, 0, 0);
    step("rst_rd_pr5", 4'b0001, 32'd0, 32'd0, 32'd0, 32'd0);

    drive_rd(4'b0000, 0, 0, 0, 0);
    drive_wb(1, 2, V2, 1, 4, V4);
    step("wr_2_4", 4'b0000, 0, 0, 0, 0);
    drive_wb(1, 6, V6, 1, 8, V8);
    step("wr_6_8", 4'b0000, 0, 0, 0, 0);

    // All four on bank 0, held valid: grants rotate and wrap back to rr0.
    drive_wb(0, 0, 0, 0, 0, 0);
    drive_rd(4'b1111, 2, 4, 6, 8);
    step("rr_c0", 4'b0001, V2, 0, 0, 0);
    step("rr_c1", 4'b0010, 0, V4, 0, 0);
    step("rr_c2", 4'b0100, 0, 0, V6, 0);
    step("rr_c3", 4'b1000, 0, 0, 0, V8);
    step("rr_wrap", 4'b0001, V2, 0, 0, 0);

    drive_rd(4'b0000, 0, 0, 0, 0);
    drive_wb(1, 6, 32'hDEAD_BEEF, 0, 0, 0);
    step("wr6", 4'b0000, 0, 0, 0, 0);
    drive_wb(0, 0, 0, 0, 0, 0);
    drive_rd(4'b0010, 0, 6, 0, 0);
    step("rd6", 4'b0010, 0, 32'hDEAD_BEEF, 0, 0);

    drive_wb(1, 9, 32'h1111_1111, 1, 9, 32'h2222_2222);
    drive_rd(4'b0100, 0, 0, 9, 0);
    step("fwd9", 4'b0100, 0, 0, 32'h2222_2222, 0);
    drive_wb(0, 0, 0, 0, 0, 0);
    step("arr9", 4'b0100, 0, 0, 32'h2222_2222, 0);

    drive_rd(4'b0011, 2, 3, 0, 0);
    step("par_banks", 4'b0011, V2, 32'd0, 0, 0);

    drive_wb(1, 0, 32'hFFFF_FFFF, 0, 0, 0);
    drive_rd(4'b1111, 0, 0, 0, 0);
    step("pr0", 4'b1111, 32'd0, 32'd0, 32'd0, 32'd0);

    // Pointers were bank0=1, bank1=2 before the PR 0 reads and must be unchanged.
    drive_wb(0, 0, 0, 0, 0, 0);
    drive_rd(4'b1111, 2, 4, 9, 5);
    step("ptr_keep", 4'b0110, 0, V4, 32'h2222_2222, 0);
    step("ptr_next", 4'b1001, V2, 0, 0, 32'd0);

    drive_rd(4'b1000, 0, 0, 0, 0);
    step("pr0_arr", 4'b1000, 0, 0, 0, 32'd0);

    // Asynchronous reset while a response is showing and another request is pending.
    drive_rd(4'b0001, 6, 0, 0, 0);
    step("pre_rst", 4'b0001, 32'hDEAD_BEEF, 0, 0, 0);
    drive_rd(4'b0010, 0, 2, 0, 0);
    #2;
    nRST = 1'b0;
    #1;
    check("mid_rst_valid", 32'(bus.read_resp_valid_by_rr), 32'd0);
    check("mid_rst_data0", bus.read_resp_data_by_rr[0], 32'd0);
    @(posedge CLK);
    #1;
    check("mid_rst_drop", 32'(bus.read_resp_valid_by_rr), 32'd0);
    drive_rd(4'b0000, 0, 0, 0, 0);
    @(negedge CLK);
    nRST = 1'b1;
    @(posedge CLK);
    #1;

    drive_rd(4'b0001, 6, 0, 0, 0);
    step("post_rst_pr6", 4'b0001, 32'd0, 0, 0, 0);
    drive_rd(4'b1111, 2, 4, 6, 8);
    step("post_rst_ptr", 4'b0010, 0, 32'd0, 0, 0);
    drive_rd(4'b0000, 0, 0, 0, 0);
    step("drain", 4'b0000, 0, 0, 0, 0);
    check("sb_empty", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/prf_banked_arb.md
# prf_banked_arb

Parametrised, banked physical register file with arbitrated, registered reads and same-cycle writeback forwarding. It generalises the flat PRF: data width, PR count, requester counts and bank count are parameters. Each bank has a limited number of read ports, arbitrated round-robin with a valid/ready handshake. It sits between the issue/operand-collect stage (read requesters) and the writeback buses (write requesters).

## Interface
- PR_COUNT, 64: physical registers; power of 2. LOG_PR_COUNT = $clog2(PR_COUNT).
- DATA_WIDTH, 32: register width.
- RR_COUNT, 4: read requesters.
- WR_COUNT, 2: write requesters.
- BANK_COUNT, 2: banks; power of 2, ≤ PR_COUNT. Bank = PR[log2(BANK_COUNT)-1:0].
- PORTS_PER_BANK, 1: read grants per bank per cycle; 1..RR_COUNT.

Ports:
- CLK  in  1  clock; one clock domain.
- nRST  in  1  asynchronous, active-low reset.
- read_req_valid_by_rr  in  RR_COUNT  read request valid.
- read_req_PR_by_rr  in  RR_COUNT×LOG_PR_COUNT  requested PR.
- read_req_ready_by_rr  out  RR_COUNT  grant; combinational from the current request and the pointer state.
- read_resp_valid_by_rr  out  RR_COUNT  response valid, registered.
- read_resp_data_by_rr  out  RR_COUNT×DATA_WIDTH  response data, registered.
- WB_valid_by_wr  in  WR_COUNT  writeback valid; always accepted.
- WB_data_by_wr  in  WR_COUNT×DATA_WIDTH  writeback data.
- WB_PR_by_wr  in  WR_COUNT×LOG_PR_COUNT  writeback PR.

## Operation
- **Storage:** PR_COUNT×DATA_WIDTH flops. PR 0 reads as 0 and ignores writes.
- **Writes:**
  - Each valid WB with PR≠0 updates its entry at the clock edge.
  - If several wr target the same PR in one cycle, the highest wr index wins.
- **PR 0 reads:** a valid request for PR 0 is always granted, consumes no bank port and returns 0.
- **Arbitration (bank b):**
  - Each bank holds a round-robin pointer rr_ptr[b] (0..RR_COUNT-1).
  - Scan requesters starting at rr_ptr[b] and wrapping: ptr, ptr+1, …, ptr+RR_COUNT-1 (mod RR_COUNT).
  - Grant the first PORTS_PER_BANK valid requesters whose PR≠0 maps to bank b.
- **Pointer update:** if bank b granted at least one requester, rr_ptr[b] ← (index of the last granted requester + 1) mod RR_COUNT. Otherwise rr_ptr[b] is unchanged.
- **Handshake:**
  - A request transfers when valid & ready.
  - A requester not granted holds valid and PR stable until granted. Behaviour when PR changes under a stalled request is not checked; the new PR is simply arbitrated.
  - Ready may be high while valid is low only as a don't-care; the bench checks ready only when valid is high.
- **Response data for requester r granted in cycle N:**
  - Data is the array value at N, overridden by forwarding.
  - Forwarding: if any WB in cycle N has valid, PR≠0 and PR equal to the requested PR, the data is that WB's data (highest wr wins).
- **Response valid:** read_resp_valid_by_rr[r] is high in N+1 iff r was granted in N; otherwise low. read_resp_data_by_rr[r] holds its last value when not valid.
- **Reset values:** all array entries 0, all rr_ptr 0, read_resp_valid_by_rr 0, read_resp_data_by_rr 0. read_req_ready_by_rr is combinational; during reset it follows arbitration with the pointers at 0.

## Timing
- Read latency: 1 cycle from grant edge to response (request at N, response valid/data at N+1).
- Write-to-read:
  - A write at N is forwarded to a read granted at N.
  - The array holds the written value from N+1.
- Back-to-back:
  - A requester may be granted every cycle.
  - Response valid may stay high on consecutive cycles.
- Reset mid-operation (nRST falling asynchronously):
  - Responses and pointers clear immediately.
  - Pending grants are dropped and produce no response.
  - The array clears to 0.
- Simultaneous events:
  - Read and write to the same PR in the same cycle → forwarded data, never the stale value.
  - Two reads to the same PR compete for bank ports like any other reads; there is no coalescing.
- Full conflict: all RR_COUNT requesters on one bank with PORTS_PER_BANK=1 → exactly one grant per cycle, rotating. Every requester is granted within RR_COUNT cycles (starvation-free).

## Test plan
All scenarios use the default parameters.

- **Reset:** assert nRST=0 → resp_valid=0 and resp_data=0 on all rr. Then release, read PR 5 on rr0 → data 0x0000_0000 at N+1.
- **Write then read:** write PR 6=0xDEAD_BEEF at cycle N, read PR 6 on rr1 at N+1 → resp_valid[1]=1 and data 0xDEAD_BEEF at N+2.
- **Forwarding and WB priority:**
  - Cycle N: wr0 writes PR 9=0x1111_1111 and wr1 writes PR 9=0x2222_2222; rr2 reads PR 9 in the same cycle.
  - Required: response data 0x2222_2222 at N+1, and the array holds 0x2222_2222 afterwards.
- **Bank conflict round-robin:**
  - rr0..rr3 all request bank-0 PRs (2, 4, 6, 8) and are held valid.
  - Required grants: rr0, rr1, rr2, rr3 on cycles N..N+3, one per cycle, ready low on the others.
  - After the 4 grants, rr_ptr[0] = 0.
- **Parallel banks:** rr0→PR 2 (bank 0) and rr1→PR 3 (bank 1) in the same cycle → both ready=1 and both responses valid at N+1.
- **PR 0:**
  - wr0 writes PR 0=0xFFFF_FFFF.
  - In the same cycle rr0..rr3 all read PR 0 → all granted, all data 0.
  - rr_ptr unchanged.
